ahb_gpio_sequencer: RTL and testbench
=====================================

# ahb_gpio_sequencer

AHB-Lite master that shares the GPIO peripheral between several on-chip requesters. Each requester issues a simple op (write data, write direction, read data) over a valid/ack handshake. A round-robin arbiter picks one request at a time, and the sequencer runs a single-beat AHB transfer to the GPIO register map. It also keeps a sticky record of the GPIO parity-error line. It sits between the requester logic and the AHB interconnect port that feeds the GPIO slave.

## Interface
- NREQ, 2, number of requesters (2..8)
- BASE_ADDR, 32'h5300_0000, GPIO data register address; direction register at BASE_ADDR+4
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- HADDR  out  32  AHB address
- HTRANS  out  2  AHB transfer type (IDLE 2'b00, NONSEQ 2'b10 only)
- HWRITE  out  1  AHB write
- HSIZE  out  3  constant 3'b010
- HWDATA  out  32  write data, {16'h0, wdata}
- HREADY  in  1  AHB ready
- HRDATA  in  32  AHB read data; bits [15:0] used
- req_valid  in  NREQ  per-requester request
- req_op  in  NREQ×2  per-requester op: 00 write DATA, 01 write DIR, 10 read DATA, 11 reserved
- req_wdata  in  NREQ×16  per-requester write data
- req_ack  out  NREQ  one-cycle completion pulse, one-hot
- rsp_rdata  out  16  read result, valid with req_ack
- rsp_err  out  1  reserved op flag, valid with req_ack
- parity_err_in  in  1  GPIO PARITYERR
- parity_err_clr  in  1  clears sticky flag
- parity_err  out  1  sticky parity error

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- **IDLE.** HTRANS=IDLE. If any req_valid is set, the arbiter grants one requester. Its op and wdata are latched and the FSM moves to ADDR, except op 11, which goes straight to RESP with rsp_err=1.
- **ADDR.** HTRANS=NONSEQ.
  - HADDR = BASE_ADDR for op 00 and op 10; BASE_ADDR+4 for op 01.
  - HWRITE=1 for op 00 and op 01.
  - Hold until HREADY=1 at a rising edge, then go to DATA.
- **DATA.** HTRANS=IDLE. HWDATA is driven with the latched wdata. Hold until HREADY=1; on that edge capture HRDATA[15:0] into rsp_rdata (reads only), then go to RESP.
- **RESP.**
  - req_ack[grant]=1 for exactly one cycle; rsp_err=1 only for op 11.
  - Return to IDLE.
  - rsp_rdata holds its value until the next read completes.
- **Arbitration.** Round-robin. The highest priority goes to the index after the last granted one. After reset, index 0 has highest priority.
- **Handshake.** A requester holds req_valid, op and wdata stable until req_ack. The request is captured at grant, so deasserting it afterwards does not abort the transfer. req_valid seen in the RESP cycle is not re-granted until IDLE.
- **Parity flag.** parity_err is set on any cycle with parity_err_in=1. It clears on parity_err_clr. If set and clear happen in the same cycle, set wins.

## Timing
- Reset values:
  - State = IDLE; HADDR=0, HTRANS=IDLE, HWRITE=0, HWDATA=0.
  - req_ack=0, rsp_rdata=0, rsp_err=0, parity_err=0.
  - Arbiter pointer = 0.
- Reset mid-transfer aborts immediately. Pending requests are dropped and requesters must re-issue.
- Latency with HREADY=1: request in IDLE at cycle 0 → ADDR cycle 1 → DATA cycle 2 → req_ack cycle 3 → IDLE cycle 4, which can grant again. Throughput is one op per 4 cycles.
- Each HREADY=0 cycle in ADDR or DATA adds one cycle. Outputs stay stable while stalled.
- Op 11: grant at cycle 0, req_ack with rsp_err at cycle 1, no bus activity.
- All outputs are registered.

## Structure
- Package gpio_seq_pkg contains:
  - op enum (OP_WR_DATA, OP_WR_DIR, OP_RD_DATA, OP_RSVD);
  - state enum;
  - HTRANS constants;
  - DATA_OFS=0, DIR_OFS=4.
- Sub-module rr_arbiter, parameterised by NREQ. Inputs are the request vector and an advance strobe. It outputs a one-hot grant and an index. The pointer updates on advance, which is asserted at IDLE→grant.

## Test plan
- Single write DIR: requester 0, op 01, wdata 16'h0001 → ADDR cycle HADDR=32'h5300_0004, HWRITE=1, HTRANS=2'b10; DATA cycle HWDATA=32'h0000_0001; req_ack[0] at cycle 3.
- Read DATA with one wait state: HREADY low for 1 DATA cycle, HRDATA=32'h0000_A5A5 → rsp_rdata=16'hA5A5, req_ack[1] at cycle 4.
- Contention: both requesters valid continuously → grants alternate 0,1,0,1; no starvation; each ack one-hot.
- Reserved op 11 → req_ack one cycle after grant, rsp_err=1, HTRANS stays IDLE.
- Parity: pulse parity_err_in for 1 cycle → parity_err=1 and stays set; parity_err_clr together with parity_err_in → stays 1; clr alone → 0.
- Reset asserted during DATA → all outputs at reset values asynchronously; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/gpio_seq_pkg.sv
// gpio_seq_pkg
// Shared types and constants for the AHB GPIO sequencer:
//   op_e      - requester operation codes
//   state_e   - sequencer FSM states
//   HTRANS_*  - the two AHB transfer types the sequencer emits
//   *_OFS     - GPIO register offsets from the block base address
package gpio_seq_pkg;

    typedef enum logic [1:0] {
        OP_WR_DATA = 2'b00,
        OP_WR_DIR  = 2'b01,
        OP_RD_DATA = 2'b10,
        OP_RSVD    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_e;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

    localparam logic [31:0] DATA_OFS = 32'd0;
    localparam logic [31:0] DIR_OFS  = 32'd4;

    // Only the direction write targets the second register.
    function automatic logic [31:0] reg_offset(input op_e op);
        return (op == OP_WR_DIR) ? DIR_OFS : DATA_OFS;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter. The pointer holds the index with the highest
// priority; after a grant it moves to the index following the winner.
// Ports:
//   HCLK, HRESETn  - clock, asynchronous active-low reset
//   req            - request vector
//   advance        - strobe: the current grant has been taken
//   grant          - one-hot grant (combinational from req and pointer)
//   grant_idx      - index of the granted requester
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx
);

    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] cand;
    logic            found;

    // Scan from the pointer upward with wrap; first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        cand      = ptr;
        found     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDXW'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDXW'(1);
        end
    end

endmodule

// File: rtl/ahb_gpio_sequencer.sv
// ahb_gpio_sequencer
// AHB-Lite master sharing the GPIO register block between NREQ requesters.
// One request is granted at a time (round-robin) and executed as a
// single-beat AHB transfer; a sticky flag records GPIO parity errors.
// Ports:
//   HCLK, HRESETn                    - clock, asynchronous active-low reset
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA - AHB master outputs (registered)
//   HREADY, HRDATA                   - AHB slave response
//   req_valid/req_op/req_wdata       - per-requester request, flattened
//   req_ack                          - one-hot completion pulse
//   rsp_rdata, rsp_err               - result, valid with req_ack
//   parity_err_in/_clr, parity_err   - sticky GPIO parity error flag
module ahb_gpio_sequencer #(
    parameter int          NREQ      = 2,
    parameter logic [31:0] BASE_ADDR = 32'h5300_0000
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    output logic [31:0]       HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [31:0]       HWDATA,
    input  logic              HREADY,
    input  logic [31:0]       HRDATA,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*2-1:0] req_op,
    input  logic [NREQ*16-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ack,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_err,
    input  logic              parity_err_in,
    input  logic              parity_err_clr,
    output logic              parity_err
);

    import gpio_seq_pkg::*;

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state, state_n;
    op_e             op_q, op_n;
    logic [15:0]     wdata_q, wdata_n;
    logic [IDXW-1:0] idx_q, idx_n;

    logic [31:0]     haddr_n;
    logic [1:0]      htrans_n;
    logic            hwrite_n;
    logic [31:0]     hwdata_n;
    logic [NREQ-1:0] ack_n;
    logic [15:0]     rdata_n;
    logic            err_n;

    logic            advance;
    logic [NREQ-1:0] grant;
    logic [IDXW-1:0] grant_idx;

    logic [1:0]      op_arr [NREQ];
    logic [15:0]     wd_arr [NREQ];

    logic            unused_hrdata;
    assign unused_hrdata = ^HRDATA[31:16];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_arr[g] = req_op[g*2 +: 2];
        assign wd_arr[g] = req_wdata[g*16 +: 16];
    end

    assign HSIZE = 3'b010;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req       (req_valid),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Next-state logic also computes the next value of every bus/response
    // output so that all outputs leave this module straight from flops.
    always_comb begin
        state_n  = state;
        op_n     = op_q;
        wdata_n  = wdata_q;
        idx_n    = idx_q;
        haddr_n  = HADDR;
        htrans_n = HTRANS_IDLE;
        hwrite_n = HWRITE;
        hwdata_n = HWDATA;
        ack_n    = '0;
        rdata_n  = rsp_rdata;
        err_n    = 1'b0;
        advance  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req_valid) begin
                    advance = 1'b1;
                    op_n    = op_e'(op_arr[grant_idx]);
                    wdata_n = wd_arr[grant_idx];
                    idx_n   = grant_idx;
                    if (op_n == OP_RSVD) begin
                        // Reserved op completes at once, without a bus transfer.
                        state_n = ST_RESP;
                        ack_n   = grant;
                        err_n   = 1'b1;
                    end else begin
                        state_n  = ST_ADDR;
                        htrans_n = HTRANS_NONSEQ;
                        haddr_n  = BASE_ADDR + reg_offset(op_n);
                        hwrite_n = (op_n != OP_RD_DATA);
                    end
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_n  = ST_DATA;
                    hwdata_n = {16'h0, wdata_q};
                end else begin
                    htrans_n = HTRANS_NONSEQ;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    state_n      = ST_RESP;
                    ack_n[idx_q] = 1'b1;
                    if (op_q == OP_RD_DATA) begin
                        rdata_n = HRDATA[15:0];
                    end
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            op_q      <= OP_WR_DATA;
            wdata_q   <= '0;
            idx_q     <= '0;
            HADDR     <= '0;
            HTRANS    <= HTRANS_IDLE;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
            req_ack   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            op_q      <= op_n;
            wdata_q   <= wdata_n;
            idx_q     <= idx_n;
            HADDR     <= haddr_n;
            HTRANS    <= htrans_n;
            HWRITE    <= hwrite_n;
            HWDATA    <= hwdata_n;
            req_ack   <= ack_n;
            rsp_rdata <= rdata_n;
            rsp_err   <= err_n;
        end
    end

    // Sticky parity flag; a new error in the clearing cycle keeps it set.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            parity_err <= 1'b0;
        end else if (parity_err_in) begin
            parity_err <= 1'b1;
        end else if (parity_err_clr) begin
            parity_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ahb_gpio_sequencer.sv
// tb_ahb_gpio_sequencer
// Self-checking bench for ahb_gpio_sequencer: directed scenarios followed by
// randomized requests, compared against a transaction-level model.
module tb_ahb_gpio_sequencer;

    localparam int          NREQ = 2;
    localparam logic [31:0] BASE = 32'h5300_0000;

    logic                HCLK;
    logic                HRESETn;
    logic [31:0]         HADDR;
    logic [1:0]          HTRANS;
    logic                HWRITE;
    logic [2:0]          HSIZE;
    logic [31:0]         HWDATA;
    logic                HREADY;
    logic [31:0]         HRDATA;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*2-1:0]   req_op;
    logic [NREQ*16-1:0]  req_wdata;
    logic [NREQ-1:0]     req_ack;
    logic [15:0]         rsp_rdata;
    logic                rsp_err;
    logic                parity_err_in;
    logic                parity_err_clr;
    logic                parity_err;

    int checks   = 0;
    int failures = 0;

    // Model state: next highest-priority requester, last read value, flag.
    int          model_ptr;
    logic [15:0] model_rdata;
    logic        model_par;

    logic [1:0]  op_arr [NREQ];
    logic [15:0] wd_arr [NREQ];

    always_comb begin
        req_op    = '0;
        req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_op[i*2 +: 2]     = op_arr[i];
            req_wdata[i*16 +: 16] = wd_arr[i];
        end
    end

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_gpio_sequencer #(.NREQ(NREQ), .BASE_ADDR(BASE)) dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .HADDR          (HADDR),
        .HTRANS         (HTRANS),
        .HWRITE         (HWRITE),
        .HSIZE          (HSIZE),
        .HWDATA         (HWDATA),
        .HREADY         (HREADY),
        .HRDATA         (HRDATA),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_wdata      (req_wdata),
        .req_ack        (req_ack),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .parity_err_in  (parity_err_in),
        .parity_err_clr (parity_err_clr),
        .parity_err     (parity_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One clock: update the parity model from this cycle's inputs, then
    // check the flag just after the edge.
    task automatic tick();
        if (!HRESETn)            model_par = 1'b0;
        else if (parity_err_in)  model_par = 1'b1;
        else if (parity_err_clr) model_par = 1'b0;
        @(posedge HCLK);
        #1;
        checkOutput("parity_err", {31'h0, parity_err}, {31'h0, model_par});
    endtask

    task automatic applyStimulus(input int r, input logic [1:0] op, input logic [15:0] wd);
        op_arr[r]    = op;
        wd_arr[r]    = wd;
        req_valid[r] = 1'b1;
    endtask

    // Runs one granted transaction starting in the current IDLE cycle.
    // wa/wd_wait: HREADY-low cycles in ADDR/DATA; keep: requester re-requests.
    task automatic runTxn(input int wa, input int wd_wait, input logic [15:0] rd, input bit keep);
        int              pick;
        logic [1:0]      op;
        logic [15:0]     wdat;
        logic [NREQ-1:0] exp_ack;
        logic [31:0]     exp_addr;
        pick = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (pick < 0 && req_valid[(model_ptr + k) % NREQ]) pick = (model_ptr + k) % NREQ;
        end
        if (pick < 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL no_request observed=none expected=pending");
            return;
        end
        op        = op_arr[pick];
        wdat      = wd_arr[pick];
        exp_ack   = '0;
        exp_ack[pick] = 1'b1;
        model_ptr = (pick + 1) % NREQ;
        exp_addr  = BASE + ((op == 2'b01) ? 32'd4 : 32'd0);
        tick();
        if (op == 2'b11) begin
            checkOutput("rsvd_ack",    {30'h0, req_ack}, {30'h0, exp_ack});
            checkOutput("rsvd_err",    {31'h0, rsp_err}, 32'd1);
            checkOutput("rsvd_htrans", {30'h0, HTRANS},  32'd0);
            checkOutput("rsvd_rdata",  {16'h0, rsp_rdata}, {16'h0, model_rdata});
            if (!keep) req_valid[pick] = 1'b0;
            tick();
            checkOutput("rsvd_ack_clr", {30'h0, req_ack}, 32'd0);
            checkOutput("rsvd_htrans2", {30'h0, HTRANS},  32'd0);
            return;
        end
        checkOutput("addr_htrans", {30'h0, HTRANS}, 32'd2);
        checkOutput("addr_haddr",  HADDR, exp_addr);
        checkOutput("addr_hwrite", {31'h0, HWRITE}, {31'h0, (op != 2'b10)});
        checkOutput("addr_ack",    {30'h0, req_ack}, 32'd0);
        for (int k = 0; k < wa; k++) begin
            HREADY = 1'b0;
            tick();
            checkOutput("addr_stall_htrans", {30'h0, HTRANS}, 32'd2);
            checkOutput("addr_stall_haddr",  HADDR, exp_addr);
        end
        HREADY = 1'b1;
        tick();
        checkOutput("data_htrans", {30'h0, HTRANS}, 32'd0);
        checkOutput("data_hwdata", HWDATA, {16'h0, wdat});
        checkOutput("data_ack",    {30'h0, req_ack}, 32'd0);
        for (int k = 0; k < wd_wait; k++) begin
            HREADY = 1'b0;
            tick();
            checkOutput("data_stall_htrans", {30'h0, HTRANS}, 32'd0);
            checkOutput("data_stall_hwdata", HWDATA, {16'h0, wdat});
            checkOutput("data_stall_ack",    {30'h0, req_ack}, 32'd0);
        end
        HREADY = 1'b1;
        HRDATA = {16'($urandom), rd};
        tick();
        if (op == 2'b10) model_rdata = rd;
        checkOutput("resp_ack",   {30'h0, req_ack}, {30'h0, exp_ack});
        checkOutput("resp_err",   {31'h0, rsp_err}, 32'd0);
        checkOutput("resp_rdata", {16'h0, rsp_rdata}, {16'h0, model_rdata});
        HRDATA = $urandom;
        if (!keep) req_valid[pick] = 1'b0;
        tick();
        checkOutput("idle_ack",   {30'h0, req_ack}, 32'd0);
        checkOutput("idle_htrans", {30'h0, HTRANS}, 32'd0);
        checkOutput("idle_rdata", {16'h0, rsp_rdata}, {16'h0, model_rdata});
    endtask

    initial begin
        HRESETn        = 1'b0;
        HREADY         = 1'b1;
        HRDATA         = '0;
        req_valid      = '0;
        parity_err_in  = 1'b0;
        parity_err_clr = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            op_arr[i] = 2'b00;
            wd_arr[i] = 16'h0;
        end
        model_ptr   = 0;
        model_rdata = 16'h0;
        model_par   = 1'b0;

        tick();
        tick();
        checkOutput("rst_htrans", {30'h0, HTRANS}, 32'd0);
        checkOutput("rst_haddr",  HADDR, 32'd0);
        checkOutput("rst_hsize",  {29'h0, HSIZE}, 32'd2);
        checkOutput("rst_ack",    {30'h0, req_ack}, 32'd0);
        HRESETn = 1'b1;
        tick();

        $display("[TB] single write DIR");
        applyStimulus(0, 2'b01, 16'h0001);
        runTxn(0, 0, 16'h0, 1'b0);

        $display("[TB] read DATA with one DATA wait state");
        applyStimulus(1, 2'b10, 16'h0);
        runTxn(0, 1, 16'hA5A5, 1'b0);

        $display("[TB] contention");
        applyStimulus(0, 2'b00, 16'h1111);
        applyStimulus(1, 2'b00, 16'h2222);
        for (int n = 0; n < 4; n++) begin
            runTxn(0, 0, 16'h0, 1'b1);
        end
        req_valid = '0;
        tick();

        $display("[TB] reserved op");
        applyStimulus(0, 2'b11, 16'hDEAD);
        runTxn(0, 0, 16'h0, 1'b0);

        $display("[TB] parity flag");
        parity_err_in = 1'b1;
        tick();
        parity_err_in = 1'b0;
        tick();
        tick();
        parity_err_in  = 1'b1;
        parity_err_clr = 1'b1;
        tick();
        parity_err_in  = 1'b0;
        tick();
        parity_err_clr = 1'b0;
        tick();

        $display("[TB] randomized requests");
        for (int n = 0; n < 150; n++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!req_valid[r] && $urandom_range(0, 2) != 0)
                    applyStimulus(r, 2'($urandom_range(0, 3)), 16'($urandom));
            end
            if (req_valid == '0) applyStimulus(0, 2'($urandom_range(0, 3)), 16'($urandom));
            parity_err_in  = ($urandom_range(0, 7) == 0);
            parity_err_clr = ($urandom_range(0, 3) == 0);
            runTxn($urandom_range(0, 2), $urandom_range(0, 2), 16'($urandom), 1'b0);
        end
        parity_err_in  = 1'b0;
        parity_err_clr = 1'b0;
        for (int n = 0; n < NREQ; n++) begin
            if (req_valid != '0) runTxn(0, 0, 16'($urandom), 1'b0);
        end

        $display("[TB] reset during DATA");
        applyStimulus(0, 2'b10, 16'h0);
        runTxn(0, 0, 16'h5A5A, 1'b0);
        parity_err_in = 1'b1;
        applyStimulus(1, 2'b00, 16'hBEEF);
        tick();
        parity_err_in = 1'b0;
        tick();
        #2;
        HRESETn   = 1'b0;
        model_par = 1'b0;
        #1;
        checkOutput("arst_haddr",  HADDR, 32'd0);
        checkOutput("arst_htrans", {30'h0, HTRANS}, 32'd0);
        checkOutput("arst_hwrite", {31'h0, HWRITE}, 32'd0);
        checkOutput("arst_hwdata", HWDATA, 32'd0);
        checkOutput("arst_ack",    {30'h0, req_ack}, 32'd0);
        checkOutput("arst_rdata",  {16'h0, rsp_rdata}, 32'd0);
        checkOutput("arst_err",    {31'h0, rsp_err}, 32'd0);
        checkOutput("arst_parity", {31'h0, parity_err}, 32'd0);
        req_valid = '0;
        tick();
        tick();
        HRESETn     = 1'b1;
        model_ptr   = 0;
        model_rdata = 16'h0;
        tick();
        applyStimulus(1, 2'b00, 16'h0F0F);
        applyStimulus(0, 2'b01, 16'h00F0);
        runTxn(0, 0, 16'h0, 1'b0);
        runTxn(0, 0, 16'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
